// File: rtl/synapse_scheduler.sv
// Timestep sequencer for the SNN synapse layer: serial current accumulation over
// spiking pre-neurons, neuron handshake, and an optional read-modify-write STDP pass.
module synapse_scheduler #(
    parameter int PRE_NEURONS  = 500,
    parameter int POST_NEURONS = 10,
    parameter int WEIGHT_WIDTH = 8,
    parameter int CUR_WIDTH    = 16,
    parameter int ADDR_WIDTH   = 9
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic                                 learning_enable,
    input  logic [PRE_NEURONS-1:0]               pre_spikes,
    input  logic                                 post_valid,
    input  logic [POST_NEURONS-1:0]              post_spikes,
    output logic                                 wt_rd_en,
    output logic [ADDR_WIDTH-1:0]                wt_addr,
    input  logic [POST_NEURONS*WEIGHT_WIDTH-1:0] wt_rd_data,
    output logic                                 wt_wr_en,
    output logic [POST_NEURONS*WEIGHT_WIDTH-1:0] wt_wr_data,
    output logic [POST_NEURONS*CUR_WIDTH-1:0]    post_currents,
    output logic                                 neuron_step,
    output logic                                 busy,
    output logic                                 done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_DRAIN,
        S_FIRE,
        S_WAIT,
        S_STDP,
        S_FIN
    } state_t;

    localparam logic [ADDR_WIDTH-1:0]   LAST_IDX = ADDR_WIDTH'(PRE_NEURONS - 1);
    localparam logic [WEIGHT_WIDTH-1:0] W_HI     = WEIGHT_WIDTH'(250);
    localparam logic [WEIGHT_WIDTH-1:0] W_LO     = WEIGHT_WIDTH'(5);
    localparam logic [WEIGHT_WIDTH-1:0] INC_PQ   = WEIGHT_WIDTH'(5);
    localparam logic [WEIGHT_WIDTH-1:0] DEC_P    = WEIGHT_WIDTH'(3);
    localparam logic [WEIGHT_WIDTH-1:0] INC_Q    = WEIGHT_WIDTH'(2);

    state_t                             state_q, state_d;
    logic [ADDR_WIDTH-1:0]              idx_q, idx_d;
    logic                               phase_q, phase_d;
    logic                               acc_pend_q, acc_pend_d;
    logic                               learn_q, learn_d;
    logic [PRE_NEURONS-1:0]             pre_q, pre_d;
    logic [POST_NEURONS-1:0]            post_q, post_d;
    logic [POST_NEURONS*CUR_WIDTH-1:0]  cur_q, cur_d;

    logic                               pre_bit;
    logic [POST_NEURONS*CUR_WIDTH-1:0]  sat_sum;
    logic [POST_NEURONS*WEIGHT_WIDTH-1:0] new_col;

    // In ACCUM this gates the read; in STDP it is the column's pre-spike.
    assign pre_bit = pre_q[idx_q];

    generate
        for (genvar gi = 0; gi < POST_NEURONS; gi++) begin : g_post
            logic [WEIGHT_WIDTH-1:0] w_i;
            logic [WEIGHT_WIDTH-1:0] upd_i;
            logic [CUR_WIDTH:0]      sum_i;

            assign w_i   = wt_rd_data[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            assign sum_i = {1'b0, cur_q[gi*CUR_WIDTH +: CUR_WIDTH]}
                         + {{(CUR_WIDTH + 1 - WEIGHT_WIDTH){1'b0}}, w_i};
            assign sat_sum[gi*CUR_WIDTH +: CUR_WIDTH] =
                sum_i[CUR_WIDTH] ? {CUR_WIDTH{1'b1}} : sum_i[CUR_WIDTH-1:0];

            always_comb begin
                upd_i = w_i;
                case ({pre_bit, post_q[gi]})
                    2'b11:   if (w_i < W_HI) upd_i = w_i + INC_PQ;
                    2'b10:   if (w_i > W_LO) upd_i = w_i - DEC_P;
                    2'b01:   if (w_i < W_HI) upd_i = w_i + INC_Q;
                    default: upd_i = w_i;
                endcase
            end

            assign new_col[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH] = upd_i;
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        phase_d     = phase_q;
        learn_d     = learn_q;
        pre_d       = pre_q;
        post_d      = post_q;
        cur_d       = cur_q;
        acc_pend_d  = 1'b0;
        wt_rd_en    = 1'b0;
        wt_wr_en    = 1'b0;
        wt_addr     = '0;
        wt_wr_data  = '0;
        neuron_step = 1'b0;
        done        = 1'b0;
        busy        = (state_q != S_IDLE);

        // Read data lands one cycle after an issued ACCUM read.
        if (acc_pend_q) begin
            cur_d = sat_sum;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pre_d   = pre_spikes;
                    learn_d = learning_enable;
                    cur_d   = '0;
                    idx_d   = '0;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                wt_addr    = idx_q;
                wt_rd_en   = pre_bit;
                acc_pend_d = pre_bit;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DRAIN: begin
                state_d = S_FIRE;
            end
            S_FIRE: begin
                neuron_step = 1'b1;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                if (post_valid) begin
                    post_d  = post_spikes;
                    idx_d   = '0;
                    phase_d = 1'b0;
                    state_d = learn_q ? S_STDP : S_FIN;
                end
            end
            S_STDP: begin
                // Alternate read / write cycles so the shared address bus never collides.
                wt_addr = idx_q;
                if (!phase_q) begin
                    wt_rd_en = 1'b1;
                    phase_d  = 1'b1;
                end else begin
                    wt_wr_en   = 1'b1;
                    wt_wr_data = new_col;
                    phase_d    = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = S_FIN;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            phase_q    <= 1'b0;
            acc_pend_q <= 1'b0;
            learn_q    <= 1'b0;
            pre_q      <= '0;
            post_q     <= '0;
            cur_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            phase_q    <= phase_d;
            acc_pend_q <= acc_pend_d;
            learn_q    <= learn_d;
            pre_q      <= pre_d;
            post_q     <= post_d;
            cur_q      <= cur_d;
        end
    end

    assign post_currents = cur_q;

endmodule
